// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle MIPS main control FSM with memory-ready handshake and timeout; `define MC_JUMP_EN enables the j instruction
module mc_main_ctrl #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 3,
  parameter int TMO_W    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                mem_ready_i,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                i_or_d_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic [1:0]          pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                instr_done_o,
  output logic                illegal_o,
  output logic                bus_err_o,
  output logic [3:0]          state_o
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXE    = 4'd6,
    R_WB     = 4'd7,
    BEQ      = 4'd8,
    I_EXE    = 4'd9,
`ifdef MC_JUMP_EN
    I_WB     = 4'd10,
    JUMP     = 4'd11
`else
    I_WB     = 4'd10
`endif
  } state_t;

  localparam logic [OP_W-1:0] OP_R     = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'b001011);
`ifdef MC_JUMP_EN
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`endif

  state_t             state, state_nxt;
  logic [TMO_W-1:0]   cnt;
  logic               is_sw, is_sltiu;
  logic               wait_st, tmo;

  assign wait_st = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign tmo     = wait_st && !mem_ready_i && (cnt == {TMO_W{1'b1}});
  assign state_o = state;

  // state register, wait counter, sticky bus error and opcode flags latched in DECODE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= FETCH;
      cnt       <= '0;
      bus_err_o <= 1'b0;
      is_sw     <= 1'b0;
      is_sltiu  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state || tmo) ? '0 : (wait_st && !mem_ready_i) ? cnt + 1'b1 : cnt;
      bus_err_o <= bus_err_o | tmo;
      if (state == DECODE) begin
        is_sw    <= instr_op_i == OP_SW;
        is_sltiu <= instr_op_i == OP_SLTIU;
      end
    end
  end

  // next state and datapath controls; strobes forced low while reset is held
  always_comb begin
    state_nxt       = state;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    i_or_d_o        = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = '0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;
    case (state)
      FETCH: begin
        mem_read_o   = 1'b1;
        alu_src_b_o  = 2'b01;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
        instr_done_o = tmo;
        state_nxt    = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        if (instr_op_i == OP_LW || instr_op_i == OP_SW) state_nxt = MEM_ADDR;
        else if (instr_op_i == OP_R) state_nxt = R_EXE;
        else if (instr_op_i == OP_BEQ) state_nxt = BEQ;
        else if (instr_op_i == OP_ADDI || instr_op_i == OP_SLTIU) state_nxt = I_EXE;
`ifdef MC_JUMP_EN
        else if (instr_op_i == OP_J) state_nxt = JUMP;
`endif
        else begin
          illegal_o    = 1'b1;
          instr_done_o = 1'b1;
          state_nxt    = FETCH;
        end
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nxt   = is_sw ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read_o   = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = tmo;
        state_nxt    = mem_ready_i ? MEM_WB : tmo ? FETCH : MEM_RD;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = FETCH;
      end
      MEM_WR: begin
        mem_write_o  = 1'b1;
        i_or_d_o     = 1'b1;
        instr_done_o = mem_ready_i | tmo;
        state_nxt    = (mem_ready_i | tmo) ? FETCH : MEM_WR;
      end
      R_EXE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_OP_W'(3'b010);
        state_nxt   = R_WB;
      end
      R_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = FETCH;
      end
      BEQ: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_OP_W'(3'b001);
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'b01;
        instr_done_o    = 1'b1;
        state_nxt       = FETCH;
      end
      I_EXE: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = is_sltiu ? ALU_OP_W'(3'b100) : ALU_OP_W'(3'b011);
        state_nxt   = I_WB;
      end
      I_WB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = FETCH;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        pc_write_o   = 1'b1;
        pc_src_o     = 2'b10;
        instr_done_o = 1'b1;
        state_nxt    = FETCH;
      end
`endif
      default: state_nxt = FETCH;
    endcase
    if (!rst_i) begin
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      reg_write_o     = 1'b0;
      instr_done_o    = 1'b0;
      illegal_o       = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: random instruction streams with random memory latency checked against an instruction-level model
module tb_mc_main_ctrl;
  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] instr_op_i = '0;
  logic       mem_ready_i = 1'b1;
  logic       mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic       alu_src_a_o;
  logic [2:0] alu_op_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, instr_done_o, illegal_o, bus_err_o;
  logic [3:0] state_o;

  mc_main_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .i_or_d_o(i_or_d_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

`ifdef MC_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal, bus_err;
    logic [3:0] state;
  } obs_t;

  obs_t       got;
  logic [8:0] strobes;
  assign got = {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o,
                pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
                reg_write_o, instr_done_o, illegal_o, bus_err_o, state_o};
  assign strobes = {mem_read_o, mem_write_o, ir_write_o, pc_write_o, pc_write_cond_o,
                    reg_write_o, instr_done_o, illegal_o, bus_err_o};

  int n_tests = 0;
  int n_fail  = 0;
  bit err     = 1'b0;
  int force_w = -1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic obs_t base(input int st);
    obs_t e = '0;
    e.state = 4'(st);
    return e;
  endfunction

  // one clock of stimulus: drive, let outputs settle, compare, advance to 2ns past the next edge
  task automatic step(input string tag, input obs_t e, input bit rdy, input logic [5:0] op);
    mem_ready_i = rdy;
    instr_op_i  = op;
    #1;
    e.bus_err = err;
    check(tag, 32'(got), 32'(e));
    @(posedge clk);
    #2;
  endtask

  // memory access with a chosen number of not-ready cycles; 15 stalls then a 16th stalled cycle abandons it
  task automatic wait_phase(input int st, output bit ok);
    int   w, r;
    obs_t e;
    bit   rdy, tmo;
    r = $urandom_range(0, 9);
    w = (force_w >= 0) ? force_w : (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(13, 15) : $urandom_range(16, 20);
    force_w = -1;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rdy = k >= w;
      tmo = !rdy && k == 15;
      e = base(st);
      if (st == 0) begin
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = rdy;
        e.pc_write  = rdy;
      end else begin
        e.mem_read  = st == 3;
        e.mem_write = st == 5;
        e.i_or_d    = 1'b1;
      end
      e.instr_done = tmo || (st == 5 && rdy);
      step(st == 0 ? "fetch" : st == 3 ? "mem_rd" : "mem_wr", e, rdy, 6'($urandom));
      if (tmo) begin
        err = 1'b1;
        return;
      end
      if (rdy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op);
    bit   ok, legal;
    obs_t e;
    wait_phase(0, ok);
    if (!ok) return;
    legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001011} || (JUMP_EN && op == 6'b000010);
    e = base(1);
    e.alu_src_b = 2'b11;
    e.illegal = !legal;
    e.instr_done = !legal;
    step("decode", e, 1'($urandom), op);
    if (!legal) return;
    case (op)
      6'b100011, 6'b101011: begin
        e = base(2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step("mem_addr", e, 1'($urandom), 6'($urandom));
        wait_phase(op == 6'b100011 ? 3 : 5, ok);
        if (ok && op == 6'b100011) begin
          e = base(4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
          step("mem_wb", e, 1'($urandom), 6'($urandom));
        end
      end
      6'b000000: begin
        e = base(6); e.alu_src_a = 1'b1; e.alu_op = 3'b010;
        step("r_exe", e, 1'($urandom), 6'($urandom));
        e = base(7); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
        step("r_wb", e, 1'($urandom), 6'($urandom));
      end
      6'b000100: begin
        e = base(8); e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_write_cond = 1'b1;
        e.pc_src = 2'b01; e.instr_done = 1'b1;
        step("beq", e, 1'($urandom), 6'($urandom));
      end
      6'b001000, 6'b001011: begin
        e = base(9); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        e.alu_op = (op == 6'b001011) ? 3'b100 : 3'b011;
        step("i_exe", e, 1'($urandom), 6'($urandom));
        e = base(10); e.reg_write = 1'b1; e.instr_done = 1'b1;
        step("i_wb", e, 1'($urandom), 6'($urandom));
      end
      default: begin
        e = base(11); e.pc_write = 1'b1; e.pc_src = 2'b10; e.instr_done = 1'b1;
        step("jump", e, 1'($urandom), 6'($urandom));
      end
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001011, 6'b000010};
    int r = $urandom_range(0, 7);
    return (r == 7) ? 6'($urandom) : ops[r];
  endfunction

  initial begin
    #3;
    check("rst_strobes", 32'(strobes), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    @(posedge clk);
    #2;
    check("rst_hold", 32'(strobes), 32'd0);
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    force_w = 0;
    run_instr(6'b100011);
    run_instr(6'b000000);
    run_instr(6'b001011);
    run_instr(6'b000010);
    force_w = 20;
    run_instr(6'b000000);
    check("bus_err_sticky", 32'(bus_err_o), 32'd1);
    for (int i = 0; i < 250; i++) run_instr(pick_op());
    force_w = 0;
    run_instr(6'b100011);
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_strobes", 32'(strobes), 32'd0);
    @(posedge clk);
    #2;
    check("midrst_hold", 32'(strobes), 32'd0);
    rst_i = 1'b1;
    err = 1'b0;
    for (int i = 0; i < 60; i++) run_instr(pick_op());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle MIPS main control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives datapath mux selects, register-file and memory strobes, and the 3-bit ALU-op code consumed by the existing ALU control.
- Adds a memory ready handshake with a timeout counter, so one shared instruction/data memory with variable latency can be used.

Parameters:
- OP_W, 6, opcode field width.
- ALU_OP_W, 3, ALU-op code width; encodings are listed under Behaviour.
- TMO_W, 4, timeout counter width; limit is 2^TMO_W-1 wait cycles.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instr_op_i  in  OP_W  opcode from the instruction register; sampled in DECODE.
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write_o  out  1  instruction register load.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load when ALU zero.
- pc_src_o  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a_o  out  1  0=PC, 1=regA.
- alu_src_b_o  out  2  00=regB, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- alu_op_o  out  ALU_OP_W  ALU-op code.
- reg_dst_o  out  1  1=rd, 0=rt.
- mem_to_reg_o  out  1  1=MDR, 0=ALUOut.
- reg_write_o  out  1  register-file write enable.
- instr_done_o  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_o  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- bus_err_o  out  1  sticky flag; set on memory timeout, cleared only by reset.
- state_o  out  4  current state, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BEQ=8, I_EXE=9, I_WB=10, JUMP=11.
- Reset (rst_i=0, asynchronous): state=FETCH, timeout counter=0, bus_err_o=0. While in reset all strobes and pulses read 0.
- Defaults: every output not listed for a state is 0.
- ALU-op codes: 000 add (addresses/PC), 001 sub (beq), 010 R-type funct, 011 addi, 100 sltiu.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, sltiu=001011, j=000010.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - ir_write and pc_write are 1 only in the cycle where mem_ready_i=1 (Mealy); state then advances to DECODE.
  - Otherwise hold FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state: lw/sw->MEM_ADDR, R->R_EXE, beq->BEQ, addi/sltiu->I_EXE, j->JUMP (see Optional Feature).
  - Any other opcode: illegal_o=1, instr_done_o=1, next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready_i=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready_i=1; in that cycle instr_done=1, then next FETCH.
- R_EXE: alu_src_a=1, alu_src_b=00, alu_op=010. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01, instr_done=1. Next FETCH.
- I_EXE: alu_src_a=1, alu_src_b=10, alu_op=011 for addi or 100 for sltiu; the op is latched in DECODE. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next FETCH.
- Timeout:
  - Counter increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i=0; it clears on any state change.
  - When the counter reaches 2^TMO_W-1 with mem_ready_i still 0: set bus_err_o, abandon the access (no ir/pc/reg write), set instr_done=1, go to FETCH.
  - mem_ready_i=1 in the limit cycle wins: normal completion, no error.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset mid-instruction: immediate return to FETCH; no further strobes are issued.
- Latency with mem_ready_i tied to 1: lw=5 cycles, sw=4, R=4, addi/sltiu=4, beq=3, j=3.

Optional Feature:
- Macro: MC_JUMP_EN.
- Defined: opcode 000010 goes DECODE->JUMP. JUMP drives pc_write=1, pc_src=10, instr_done=1, then FETCH.
- Undefined: JUMP state is absent; 000010 is illegal (illegal_o pulse, next FETCH); pc_src_o never equals 10.

Test Plan:
- Reset: hold rst_i=0, then release with mem_ready_i=1 -> state_o=0, mem_read_o=1; first cycle asserts ir_write_o=pc_write_o=1.
- lw (op 100011), mem_ready_i=1 -> states 0,1,2,3,4; reg_write_o=1 with mem_to_reg_o=1 on cycle 5; instr_done_o single pulse.
- sw (op 101011), mem_ready_i low for 3 cycles in MEM_WR -> mem_write_o=1 for 4 cycles; no reg_write_o; done on ready cycle.
- R then sltiu (op 001011) -> alu_op_o=010 in R_EXE, 100 in I_EXE; reg_dst_o=1 then 0 in WB.
- mem_ready_i stuck 0 in FETCH, TMO_W=4 -> after 15 wait cycles bus_err_o=1 and stays 1; no ir_write_o; FETCH re-entered.
- Op 000010: with MC_JUMP_EN -> pc_write_o=1, pc_src_o=10 at cycle 3; without -> illegal_o pulse in DECODE.
